// File: rtl/pulse_stretcher_pkg.sv
// Shared types and defaults for the pulse stretcher: FSM state encoding,
// default window lengths and the cycle-counter width helper.
package pulse_stretcher_pkg;

   typedef enum logic [1:0] {
      St_Idle = 2'b00,
      St_High = 2'b01,
      St_Gap  = 2'b10
   } state_t;

   localparam int DEF_HIGH_CYCLES = 4;
   localparam int DEF_LOW_CYCLES  = 2;
   localparam int DEF_PEND_W      = 2;

   // Wide enough to hold the longer of the two window lengths without wrapping.
   function automatic int cnt_width(input int high_cycles, input int low_cycles);
      return $clog2(((high_cycles > low_cycles) ? high_cycles : low_cycles) + 1);
   endfunction

endpackage

// File: rtl/pulse_stretcher_sat_updown_counter.sv
// Saturating up/down counter holding queued events; simultaneous inc and dec
// hold the value, and an inc that cannot be stored raises drop.
module sat_updown_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         full,
   output logic         drop
);

   logic empty;

   assign full  = (count == {W{1'b1}});
   assign empty = (count == '0);
   assign drop  = inc & ~dec & full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + W'(1);
      end else if (dec && !inc && !empty) begin
         count <= count - W'(1);
      end
   end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width high windows separated
// by a minimum low gap, queueing events that arrive while a window is running.
module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
   parameter int LOW_CYCLES  = DEF_LOW_CYCLES,
   parameter int PEND_W      = DEF_PEND_W
) (
   input  logic              C_CLOCK_50,
   input  logic              C_Reset,
   input  logic              C_Pulse_In,
   output logic              C_Level_Out,
   output logic              C_Busy_Out,
   output logic [PEND_W-1:0] C_Pending_Out,
   output logic              C_Overflow_Out
);

   localparam int CW = cnt_width(HIGH_CYCLES, LOW_CYCLES);

   state_t        state;
   logic [CW-1:0] cycle_cnt;
   logic          pend_nonzero;
   logic          request;
   logic          high_done;
   logic          gap_done;
   logic          launch;
   logic          pend_inc;
   logic          pend_dec;
   logic          pend_full;
   logic          pend_drop;

   assign pend_nonzero = |C_Pending_Out;
   assign request      = C_Pulse_In | pend_nonzero;
   assign high_done    = (cycle_cnt == CW'(HIGH_CYCLES - 1));
   assign gap_done     = (cycle_cnt == CW'(LOW_CYCLES - 1));

   always_comb begin
      launch = 1'b0;
      case (state)
         St_High: launch = 1'b0;
         St_Gap:  launch = gap_done & request;
         default: launch = request;
      endcase
   end

   // A launch consumes a queued event if one exists, otherwise the live pulse;
   // a live pulse not consumed directly is enqueued.
   assign pend_dec = launch & pend_nonzero;
   assign pend_inc = C_Pulse_In & ~(launch & ~pend_nonzero);

   sat_updown_counter #(
      .W(PEND_W)
   ) u_pending (
      .clk   (C_CLOCK_50),
      .rst_n (C_Reset),
      .inc   (pend_inc),
      .dec   (pend_dec),
      .count (C_Pending_Out),
      .full  (pend_full),
      .drop  (pend_drop)
   );

   always_ff @(posedge C_CLOCK_50) begin
      if (!C_Reset) begin
         state          <= St_Idle;
         cycle_cnt      <= '0;
         C_Level_Out    <= 1'b0;
         C_Busy_Out     <= 1'b0;
         C_Overflow_Out <= 1'b0;
      end else begin
         if (pend_drop) begin
            C_Overflow_Out <= 1'b1;
         end
         case (state)
            St_High: begin
               if (high_done) begin
                  state       <= St_Gap;
                  cycle_cnt   <= '0;
                  C_Level_Out <= 1'b0;
                  C_Busy_Out  <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt + CW'(1);
               end
            end
            St_Gap: begin
               if (gap_done) begin
                  cycle_cnt <= '0;
                  if (request) begin
                     state       <= St_High;
                     C_Level_Out <= 1'b1;
                     C_Busy_Out  <= 1'b1;
                  end else begin
                     state       <= St_Idle;
                     C_Level_Out <= 1'b0;
                     C_Busy_Out  <= 1'b0;
                  end
               end else begin
                  cycle_cnt <= cycle_cnt + CW'(1);
               end
            end
            default: begin
               // Also normalises the unused encoding back to idle.
               cycle_cnt <= '0;
               if (request) begin
                  state       <= St_High;
                  C_Level_Out <= 1'b1;
                  C_Busy_Out  <= 1'b1;
               end else begin
                  state       <= St_Idle;
                  C_Level_Out <= 1'b0;
                  C_Busy_Out  <= 1'b0;
               end
            end
         endcase
      end
   end

   logic unused_full;
   assign unused_full = pend_full;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench: directed scenarios plus random pulse trains, compared
// every cycle against a timeline model of windows and a queue count.
module tb_pulse_stretcher;

   localparam int H   = 4;
   localparam int L   = 2;
   localparam int PW  = 2;
   localparam int CAP = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          pulse = 1'b0;
   logic          level;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   int total = 0;
   int bad   = 0;

   // Reference model: edge index, last launch edge, first edge a new launch may occur.
   int edge_no = 0;
   int last_launch = -1000;
   int avail = 0;
   int m_pend = 0;
   int m_ovf = 0;

   always #5 clk = ~clk;

   pulse_stretcher #(
      .HIGH_CYCLES(H),
      .LOW_CYCLES (L),
      .PEND_W     (PW)
   ) dut (
      .C_CLOCK_50    (clk),
      .C_Reset       (rst),
      .C_Pulse_In    (pulse),
      .C_Level_Out   (level),
      .C_Busy_Out    (busy),
      .C_Pending_Out (pending),
      .C_Overflow_Out(overflow)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, edge_no, got, exp);
      end
   endtask

   // Apply one cycle of inputs, advance the model over that edge, check outputs.
   task automatic step(input bit r, input bit p);
      bit do_launch;
      rst   = r;
      pulse = p;
      @(posedge clk);
      edge_no++;
      if (!r) begin
         m_pend      = 0;
         m_ovf       = 0;
         avail       = edge_no;
         last_launch = edge_no - 1000;
      end else begin
         do_launch = (p || m_pend > 0) && (edge_no >= avail);
         if (do_launch) begin
            last_launch = edge_no;
            avail       = edge_no + H + L;
            if (m_pend > 0) m_pend = m_pend - 1 + int'(p);
         end else if (p) begin
            if (m_pend < CAP) m_pend++;
            else m_ovf = 1;
         end
      end
      #1;
      check("level", int'(level), int'((edge_no - last_launch) < H));
      check("busy", int'(busy), int'(edge_no < avail));
      check("pending", int'(pending), m_pend);
      check("overflow", int'(overflow), m_ovf);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0);
   endtask

   initial begin
      // Reset held with pulse high: nothing may launch.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      step(1'b1, 1'b0);
      $display("reset with pulse held: total=%0d bad=%0d", total, bad);

      idle(5);
      step(1'b1, 1'b1);
      idle(10);
      $display("single event: total=%0d bad=%0d", total, bad);

      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      idle(14);
      $display("queued pair: total=%0d bad=%0d", total, bad);

      for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
      idle(30);
      check("overflow_sticky", int'(overflow), 1);
      $display("overflow burst: total=%0d bad=%0d", total, bad);

      step(1'b1, 1'b1);
      idle(5);
      step(1'b1, 1'b1);
      idle(10);
      $display("back-to-back launch: total=%0d bad=%0d", total, bad);

      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      check("pending_before_reset", int'(pending), 2);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      idle(10);
      $display("mid-window reset: total=%0d bad=%0d", total, bad);

      foreach (dens_tab[k]) begin
         for (int i = 0; i < 200; i++) begin
            step(($urandom_range(99) != 0), ($urandom_range(99) < dens_tab[k]));
         end
         idle(12);
         $display("random density %0d%%: total=%0d bad=%0d", dens_tab[k], total, bad);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   int dens_tab[4] = '{5, 30, 70, 100};

endmodule
